fetch_sequencer: RTL and testbench

- Instruction-fetch stage directly upstream of the control decoder.
- Fetches one instruction per turn from a variable-latency instruction memory and holds it with `opcode` exported to the decoder.
- Waits for the core to resolve that instruction using the decoder's branch/jump/jr selects plus the branch-condition result.
- Then computes and registers the next PC and fetches again (non-pipelined, single outstanding request).

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/next_pc_calc.sv | 47 ++++
 rtl/fetch_sequencer.sv | 157 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   state_t      - fetch FSM states
//   OPCODE_*     - opcode field bounds within the instruction word
//   IMM_MSB      - top bit of the 16-bit branch immediate
//   JIDX_MSB     - top bit of the 26-bit jump index
//   PC_W         - program-counter width
//   ALIGN_MASK   - low PC bits that must be zero for a legal fetch address
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_ISSUE = 2'd1,
    S_FAULT = 2'd2,
    S_RETRY = 2'd3
  } state_t;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned JIDX_MSB   = 25;
  localparam int unsigned PC_W       = 32;

  localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: purely combinational next-PC selection for the fetch stage.
// Ports:
//   i_pc_plus4                  address of the held instruction + 4
//   i_instr_low                 instruction bits [25:0] (jump index / immediate)
//   i_mux_j_type_addr_to_read   0 selects the JR register target (highest priority)
//   i_mux_branch_jump           0 selects the J/JAL pseudo-direct target
//   i_branch, i_branch_taken    conditional branch taken when both are 1
//   i_jr_target                 register value for JR
//   o_next_pc                   selected next PC (modulo 2^32)
//   o_misaligned                next PC has a nonzero low bit
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0]   i_pc_plus4,
  input  logic [JIDX_MSB:0] i_instr_low,
  input  logic              i_mux_j_type_addr_to_read,
  input  logic              i_mux_branch_jump,
  input  logic              i_branch,
  input  logic              i_branch_taken,
  input  logic [PC_W-1:0]   i_jr_target,
  output logic [PC_W-1:0]   o_next_pc,
  output logic              o_misaligned
);

  logic [PC_W-1:0] w_jump_target;
  logic [PC_W-1:0] w_branch_offset;
  logic [PC_W-1:0] w_branch_target;

  assign w_jump_target   = {i_pc_plus4[PC_W-1:PC_W-4], i_instr_low, 2'b00};
  assign w_branch_offset = {{(PC_W-IMM_MSB-3){i_instr_low[IMM_MSB]}},
                            i_instr_low[IMM_MSB:0], 2'b00};
  assign w_branch_target = i_pc_plus4 + w_branch_offset;

  always_comb begin
    o_next_pc = i_pc_plus4;
    if (!i_mux_j_type_addr_to_read) begin
      o_next_pc = i_jr_target;
    end else if (!i_mux_branch_jump) begin
      o_next_pc = w_jump_target;
    end else if (i_branch && i_branch_taken) begin
      o_next_pc = w_branch_target;
    end
  end

  assign o_misaligned = |(o_next_pc[1:0] & ALIGN_MASK);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: non-pipelined instruction-fetch stage feeding the control
// decoder. Fetches one instruction, holds it until the core resolves it, then
// computes the next PC and fetches again. A misaligned next PC parks the
// stage in a sticky fault state until reset.
//
// Optional feature (macro FETCH_TIMEOUT_EN): after IMEM_TIMEOUT request cycles
// with no imem_ack, drop imem_req for one cycle (pulsing imem_timeout) and
// re-request the same address. Without the macro the request waits forever
// and imem_timeout is tied low.
//
// Ports:
//   clk, nrst                 clock; synchronous active-low reset
//   imem_req/imem_addr        fetch request and address (= pc)
//   imem_ack/imem_rdata       memory response, sampled only while requesting
//   instr/opcode/pc/pc_plus4  held instruction and its address
//   instr_valid               held instruction valid for the core
//   resolve_valid + selects   core resolution of the held instruction
//   jr_target                 register target for JR
//   misalign_err              sticky misaligned-target fault
//   imem_timeout              one-cycle retry pulse
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        resolve_valid,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic        mux_branch_jump,
  input  logic        mux_j_type_addr_to_read,
  input  logic [31:0] jr_target,
  output logic        misalign_err,
  output logic        imem_timeout
);

  if (IMEM_TIMEOUT == 0) begin : g_bad_timeout
    $error("IMEM_TIMEOUT must be at least 1");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_next_pc;
  logic            w_misaligned;
  logic            w_take_ack;
  logic            w_resolve;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_take_ack = (r_state == S_REQ) && imem_ack;
  assign w_resolve  = (r_state == S_ISSUE) && resolve_valid;

  next_pc_calc u_next_pc_calc (
    .i_pc_plus4                (w_pc_plus4),
    .i_instr_low               (r_instr[JIDX_MSB:0]),
    .i_mux_j_type_addr_to_read (mux_j_type_addr_to_read),
    .i_mux_branch_jump         (mux_branch_jump),
    .i_branch                  (branch),
    .i_branch_taken            (branch_taken),
    .i_jr_target               (jr_target),
    .o_next_pc                 (w_next_pc),
    .o_misaligned              (w_misaligned)
  );

`ifdef FETCH_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        w_tmo_hit;

  // The Nth consecutive un-acked request cycle is the last one before retry.
  assign w_tmo_hit = (r_state == S_REQ) && !imem_ack &&
                     (r_tmo_cnt == 32'(IMEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_REQ) begin
      if (imem_ack || w_tmo_hit) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 32'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (imem_ack) begin
          w_state_nxt = S_ISSUE;
`ifdef FETCH_TIMEOUT_EN
        end else if (w_tmo_hit) begin
          w_state_nxt = S_RETRY;
`endif
        end
      end
      S_ISSUE: begin
        if (resolve_valid) begin
          w_state_nxt = w_misaligned ? S_FAULT : S_REQ;
        end
      end
      S_FAULT: w_state_nxt = S_FAULT;
      S_RETRY: w_state_nxt = S_REQ;
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      if (w_take_ack) begin
        r_instr <= imem_rdata;
      end
      // The faulting target is still loaded so it stays visible on pc.
      if (w_resolve) begin
        r_pc <= w_next_pc;
      end
    end
  end

  // The state register already reads S_REQ during reset; gating with nrst
  // keeps the request low until the first cycle out of reset.
  assign imem_req     = nrst && (r_state == S_REQ);
  assign imem_addr    = r_pc;
  assign instr        = r_instr;
  assign opcode       = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign instr_valid  = (r_state == S_ISSUE);
  assign misalign_err = (r_state == S_FAULT);
  assign imem_timeout = (r_state == S_RETRY);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        resolve_valid;
  logic        branch;
  logic        branch_taken;
  logic        mux_branch_jump;
  logic        mux_j_type_addr_to_read;
  logic [31:0] jr_target;
  logic        misalign_err;
  logic        imem_timeout;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC     (32'h0000_0000),
    .IMEM_TIMEOUT (4)
  ) dut (
    .clk                     (clk),
    .nrst                    (nrst),
    .imem_req                (imem_req),
    .imem_addr               (imem_addr),
    .imem_ack                (imem_ack),
    .imem_rdata              (imem_rdata),
    .instr                   (instr),
    .opcode                  (opcode),
    .pc                      (pc),
    .pc_plus4                (pc_plus4),
    .instr_valid             (instr_valid),
    .resolve_valid           (resolve_valid),
    .branch                  (branch),
    .branch_taken            (branch_taken),
    .mux_branch_jump         (mux_branch_jump),
    .mux_j_type_addr_to_read (mux_j_type_addr_to_read),
    .jr_target               (jr_target),
    .misalign_err            (misalign_err),
    .imem_timeout            (imem_timeout)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_defaults();
    resolve_valid           = 1'b0;
    branch                  = 1'b0;
    branch_taken            = 1'b0;
    mux_branch_jump         = 1'b1;
    mux_j_type_addr_to_read = 1'b1;
    jr_target               = 32'h0;
  endtask

  // Called just after a negedge; expects the request to be up right now.
  task automatic do_fetch(input logic [31:0] word, input int unsigned wait_cycles);
    logic [31:0] a;
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed=0 entries expected=1 entry");
      return;
    end
    a = exp_q.pop_front();
    chk("req_up", imem_req, 1);
    chk("req_addr", imem_addr, a);
    chk("valid_low_in_req", instr_valid, 0);
    for (int unsigned i = 0; i < wait_cycles; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = ~word;
      @(negedge clk);
      #1;
      chk("req_held", imem_req, 1);
      chk("addr_held", imem_addr, a);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("valid_up", instr_valid, 1);
    chk("req_low_in_issue", imem_req, 0);
    chk("instr", instr, word);
    chk("opcode", {26'b0, opcode}, {26'b0, word[31:26]});
    chk("pc", pc, a);
    chk("pc_plus4", pc_plus4, a + 32'd4);
  endtask

  task automatic resolve(input logic jsel, input logic bj, input logic br, input logic bt,
                         input logic [31:0] jr, input logic [31:0] exp_next);
    mux_j_type_addr_to_read = jsel;
    mux_branch_jump         = bj;
    branch                  = br;
    branch_taken            = bt;
    jr_target               = jr;
    resolve_valid           = 1'b1;
    exp_q.push_back(exp_next);
    @(negedge clk);
    set_defaults();
  endtask

  initial begin
    nrst       = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    set_defaults();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_timeout", imem_timeout, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);

    // Straight-line fetches 0,4,8,C with zero-wait memory.
    nrst = 1'b1;
    exp_q.push_back(32'h0);
    do_fetch(32'h2001_0001, 0);
    resolve(1, 1, 0, 0, 32'h0, 32'h4);
    do_fetch(32'h2002_0002, 0);
    resolve(1, 1, 0, 0, 32'h0, 32'h8);
    do_fetch(32'h2003_0003, 0);
    resolve(1, 1, 0, 0, 32'h0, 32'hC);
    do_fetch(32'h2004_0004, 0);
    resolve(1, 1, 0, 0, 32'h0, 32'h10);

    // Branch with imm=-1 at 0x10: taken loops to 0x10, not taken falls to 0x14.
    do_fetch(32'h1000_FFFF, 0);
    resolve(1, 1, 1, 1, 32'h0, 32'h10);
    do_fetch(32'h1000_FFFF, 0);
    resolve(1, 1, 1, 0, 32'h0, 32'h14);

    // JR into the 0x1 region, then a J with index 0x40.
    do_fetch(32'h0000_0008, 0);
    resolve(0, 1, 0, 0, 32'h1000_0000, 32'h1000_0000);
    do_fetch(32'h0800_0040, 0);
    resolve(1, 0, 0, 0, 32'h0, 32'h1000_0100);

    // Ack delayed 3 cycles, then a stray ack while issuing.
    do_fetch(32'h0C00_1234, 3);
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_ack   = 1'b0;
    #1;
    chk("stray_ack_instr", instr, 32'h0C00_1234);
    chk("stray_ack_valid", instr_valid, 1);
    chk("stray_ack_req", imem_req, 0);
    // JR wins over a simultaneous jump select and taken branch.
    resolve(0, 0, 1, 1, 32'h200, 32'h200);

    // Wrap: 0xFFFF_FFFC + 4 -> 0.
    do_fetch(32'h0000_0008, 0);
    resolve(0, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    do_fetch(32'h2000_0000, 0);
    resolve(1, 1, 0, 0, 32'h0, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    #1;
    chk("tmo_req0", imem_req, 1);
    for (int unsigned i = 1; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("tmo_req_held", imem_req, 1);
      chk("tmo_no_pulse", imem_timeout, 0);
    end
    @(negedge clk);
    #1;
    chk("tmo_pulse", imem_timeout, 1);
    chk("tmo_req_drop", imem_req, 0);
    chk("tmo_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("tmo_pulse_end", imem_timeout, 0);
    exp_q.push_back(32'h0);
    do_fetch(32'h0000_0008, 0);
`else
    #1;
    for (int unsigned i = 0; i < 20; i++) begin
      chk("wait_req_held", imem_req, 1);
      chk("wait_no_timeout", imem_timeout, 0);
      @(negedge clk);
      #1;
    end
    exp_q.push_back(32'h0);
    do_fetch(32'h0000_0008, 0);
`endif

    // Misaligned JR target faults and sticks; selects and acks are ignored.
    mux_j_type_addr_to_read = 1'b0;
    jr_target               = 32'h0000_0203;
    resolve_valid           = 1'b1;
    @(negedge clk);
    set_defaults();
    #1;
    chk("fault_err", misalign_err, 1);
    chk("fault_req", imem_req, 0);
    chk("fault_valid", instr_valid, 0);
    chk("fault_pc", pc, 32'h0000_0203);
    resolve_valid = 1'b1;
    imem_ack      = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("fault_req_low", imem_req, 0);
      chk("fault_sticky", misalign_err, 1);
    end
    resolve_valid = 1'b0;
    imem_ack      = 1'b0;
    nrst          = 1'b0;
    @(negedge clk);
    #1;
    chk("rerst_err", misalign_err, 0);
    chk("rerst_req", imem_req, 0);
    chk("rerst_pc", pc, 32'h0);
    chk("rerst_instr", instr, 32'h0);
    nrst = 1'b1;
    exp_q.push_back(32'h0);
    do_fetch(32'h2005_0005, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
